// File: rtl/dma_copy.sv
// Single-channel word copy engine: reads one word from src, writes it to dst,
// repeats for len words, with alignment, timeout and abort reporting.
package bus_if_types_pkg;
  typedef enum logic {READ = 1'b0, WRITE = 1'b1} ttype;
endpackage

module dma_copy #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [31:0]            src_addr,
  input  logic [31:0]            dst_addr,
  input  logic [15:0]            len,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             err,
  output logic                   m_ss,
  output bus_if_types_pkg::ttype m_ttype,
  output logic [31:0]            m_addr,
  output logic [31:0]            m_wdata,
  input  logic [31:0]            m_rdata,
  input  logic                   m_bdone
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_FIN} state_e;
  typedef enum logic [1:0] {E_OK = 2'd0, E_ALIGN = 2'd1, E_TIMEOUT = 2'd2, E_ABORT = 2'd3} err_e;

  state_e        state_q, state_d;
  err_e          err_q, err_d;
  logic [31:0]   src_q, src_d;
  logic [31:0]   dst_q, dst_d;
  logic [15:0]   rem_q, rem_d;
  logic [31:0]   data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          abort_q, abort_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      err_q   <= E_OK;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (src_addr[1:0] != 2'b00 || dst_addr[1:0] != 2'b00) begin
            err_d   = E_ALIGN;
            state_d = S_FIN;
          end else if (len == 16'd0) begin
            err_d   = E_OK;
            state_d = S_FIN;
          end else begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            rem_d   = len;
            err_d   = E_OK;
            abort_d = 1'b0;
            cnt_d   = '0;
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (abort) abort_d = 1'b1;
        if (m_bdone) begin
          data_d  = m_rdata;
          cnt_d   = '0;
          state_d = S_WRITE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = E_TIMEOUT;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (abort) abort_d = 1'b1;
        if (m_bdone) begin
          src_d = src_q + 32'd4;
          dst_d = dst_q + 32'd4;
          rem_d = rem_q - 16'd1;
          cnt_d = '0;
          // Completion outranks a pending abort; an abort sampled on this very edge still counts.
          if (rem_q == 16'd1) begin
            err_d   = E_OK;
            state_d = S_FIN;
          end else if (abort_q || abort) begin
            err_d   = E_ABORT;
            state_d = S_FIN;
          end else begin
            state_d = S_READ;
          end
        end else if (cnt_q == TO_LAST) begin
          err_d   = E_TIMEOUT;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIN: begin
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_ss    = (state_q == S_READ) || (state_q == S_WRITE);
    m_ttype = (state_q == S_WRITE) ? bus_if_types_pkg::WRITE : bus_if_types_pkg::READ;
    m_addr  = '0;
    if (state_q == S_READ)  m_addr = src_q;
    if (state_q == S_WRITE) m_addr = dst_q;
    m_wdata = data_q;
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_FIN);
    err     = err_q;
  end

endmodule

// File: doc/dma_copy.md
DMA_COPY -- requirements
Module: dma_copy

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles per bus transaction before abort.
REQ-002 clk  in  1  single clock; all logic on posedge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-005 abort  in  1  request to stop the copy at the next transaction boundary.
REQ-006 src_addr  in  32  source byte address; must be 4-byte aligned.
REQ-007 dst_addr  in  32  destination byte address; must be 4-byte aligned.
REQ-008 len  in  16  number of 32-bit words to copy.
REQ-009 busy  out  1  high while a copy is in progress.
REQ-010 done  out  1  one-cycle pulse when a copy ends, for any cause.
REQ-011 err  out  2  status of the last copy: 0 ok, 1 unaligned, 2 timeout, 3 aborted; held until the next start.
REQ-012 m_ss  out  1  bus request (slave select), master side.
REQ-013 m_ttype  out  bus_if_types_pkg ttype  READ or WRITE.
REQ-014 m_addr  out  32  transaction address.
REQ-015 m_wdata  out  32  write data.
REQ-016 m_rdata  in  32  read data; valid in the cycle m_bdone=1.
REQ-017 m_bdone  in  1  slave completion; may be combinationally high in the same cycle as m_ss.

Function
REQ-018 States: IDLE, READ, WRITE, FIN.
REQ-019 IDLE, start=1 with src_addr[1:0]!=0 or dst_addr[1:0]!=0: latch err=1, go to FIN; no bus activity.
REQ-020 IDLE, start=1 with len=0 and aligned addresses: err=0, go to FIN; no bus activity.
REQ-021 IDLE, start=1 otherwise: latch src, dst and len into internal registers; err=0; go to READ.
REQ-022 READ: m_ss=1, m_ttype=READ, m_addr=current src.
REQ-023 READ, on an edge with m_bdone=1: capture m_rdata into the data register; go to WRITE.
REQ-024 WRITE: m_ss=1, m_ttype=WRITE, m_addr=current dst, m_wdata=data register.
REQ-025 WRITE, on an edge with m_bdone=1: src+=4 and dst+=4, both modulo 2^32; remaining-=1.
REQ-026 After a completed write: if remaining is now 0, go to FIN with err=0; else if abort is pending, go to FIN with err=3; else go to READ.
REQ-027 m_addr, m_ttype and m_wdata shall be held stable while m_ss=1 and m_bdone=0.
REQ-028 Every transaction lasts at least one cycle; m_ss never drops between back-to-back transactions.
REQ-029 Abort handling: an abort=1 sample in READ or WRITE sets an internal pending flag.
REQ-030 An in-flight transaction is never cut short by abort; a pending abort is honoured after the current READ+WRITE pair completes.
REQ-031 abort in IDLE has no effect.
REQ-032 Timeout counter: clears on entry to READ or WRITE and increments each cycle with m_ss=1 and m_bdone=0.
REQ-033 When the timeout counter reaches TIMEOUT: deassert m_ss, err=2, go to FIN; the partial word is not written.
REQ-034 FIN: done=1 for exactly one cycle, then IDLE.
REQ-035 busy=1 in READ, WRITE and FIN; busy=0 in IDLE.
REQ-036 m_ss=0 in IDLE and FIN.
REQ-037 start while busy=1 is ignored.

Reset
REQ-038 rst=1 at a posedge forces IDLE, including mid-transaction.
REQ-039 Reset values: m_ss=0, m_ttype=READ, m_addr=0, m_wdata=0, busy=0, done=0, err=0; address, length, data and timeout registers=0; abort-pending flag=0.
REQ-040 Reset mid-transaction drops m_ss in the cycle after the reset edge; no done pulse is generated.

Verification
REQ-041 Zero-wait slave (m_bdone tied 1), src=0x1000, dst=0x2000, len=3: 6 transactions at 0x1000, 0x2000, 0x1004, 0x2004, 0x1008, 0x2008; done pulse on cycle 7 after start; err=0.
REQ-042 len=0: done pulse the cycle after start; m_ss never asserted; err=0.
REQ-043 src=0x1002: done pulse and err=1 the cycle after start; no bus activity.
REQ-044 TIMEOUT=8, m_bdone held 0: m_ss high for 8 cycles then low; done pulse; err=2.
REQ-045 len=4, abort pulsed during the second READ while m_bdone stalls 3 cycles: exactly 2 words written; done pulse; err=3.
REQ-046 Slave with 2-cycle stalls: m_addr/m_wdata stable during stalls; rst during a WRITE stall gives m_ss=0 and busy=0 next cycle, with no done pulse.
